// File: rtl/flp_pkg.sv
// Shared types and constants for the FLP integer add pipeline.
package flp_pkg;

    // Operand storage width inside the pipeline; supports WIDTH up to FLP_MAX_W.
    localparam int FLP_MAX_W = 61;
    localparam int FLP_TC_W  = FLP_MAX_W + 3;

    typedef struct packed {
        logic [FLP_TC_W-1:0] op_a;
        logic [FLP_TC_W-1:0] op_b;
        logic                sa;
        logic                sb;
        logic                acc;
        logic                clr;
    } s1_payload_t;

    function automatic logic [FLP_TC_W-1:0] acc_max(input int width);
        return (FLP_TC_W'(1) << (width + 1)) - FLP_TC_W'(1);
    endfunction

endpackage

// File: rtl/flp_sm2tc.sv
// Sign-magnitude to two's-complement converter, result is WIDTH+3 bits wide.
module flp_sm2tc #(
    parameter int WIDTH = 32
) (
    input  logic             sn,
    input  logic [WIDTH-1:0] sg,
    output logic [WIDTH+2:0] tc
);

    logic [WIDTH+2:0] mag_ext;

    assign mag_ext = {3'b000, sg};
    assign tc      = sn ? ((WIDTH+3)'(0) - mag_ext) : mag_ext;

endmodule

// File: rtl/flp_iadd_pipe.sv
// Two-stage sign-magnitude adder/subtractor with valid/ready handshake.
// Define FLP_IADD_PIPE_ACC_EN to build the saturating running accumulator.
module flp_iadd_pipe
    import flp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_sn1,
    input  logic             i_sn2,
    input  logic [WIDTH-1:0] i_sg1,
    input  logic [WIDTH-1:0] i_sg2,
    input  logic             i_sub,
    input  logic             i_acc,
    input  logic             i_clr,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_sn,
    output logic [WIDTH:0]   o_sg,
    output logic             o_zero,
    output logic             o_ovf
);

    logic [WIDTH+2:0] tc1;
    logic [WIDTH+2:0] tc2;
    logic             sb_eff;
    logic             mode_acc;
    logic             mode_clr;
    logic             s1_ld;
    logic             s2_ld;

    logic             s1_v_d, s1_v_q;
    s1_payload_t      s1_d, s1_q;

    logic             o_valid_d, o_valid_q;
    logic             o_sn_d, o_sn_q;
    logic [WIDTH:0]   o_sg_d, o_sg_q;
    logic             o_zero_d, o_zero_q;
    logic             o_ovf_d, o_ovf_q;

    logic                       is_acc;
    logic signed [FLP_TC_W-1:0] add_a;
    logic signed [FLP_TC_W-1:0] sum;
    logic signed [FLP_TC_W-1:0] res;
    logic        [FLP_TC_W-1:0] mag;

    assign sb_eff = i_sn2 ^ i_sub;

    flp_sm2tc #(.WIDTH(WIDTH)) u_op1 (.sn(i_sn1),  .sg(i_sg1), .tc(tc1));
    flp_sm2tc #(.WIDTH(WIDTH)) u_op2 (.sn(sb_eff), .sg(i_sg2), .tc(tc2));

`ifdef FLP_IADD_PIPE_ACC_EN
    localparam logic signed [FLP_TC_W-1:0] ACC_MAX = acc_max(WIDTH);

    logic signed [WIDTH+1:0] acc_d, acc_q;

    function automatic logic signed [FLP_TC_W-1:0] saturate(input logic signed [FLP_TC_W-1:0] v);
        if (v > ACC_MAX)  return ACC_MAX;
        if (v < -ACC_MAX) return -ACC_MAX;
        return v;
    endfunction

    assign mode_acc = i_acc;
    assign mode_clr = i_clr;
`else
    logic unused_mode;

    assign mode_acc    = 1'b0;
    assign mode_clr    = 1'b0;
    assign unused_mode = ^{i_acc, i_clr, s1_q.acc, s1_q.clr};
`endif

    // A full stage may load only if the stage after it drains this cycle.
    assign s2_ld   = ~o_valid_q | i_ready;
    assign s1_ld   = ~s1_v_q | s2_ld;
    assign o_ready = s1_ld;

    // ---- S1: operand conversion ----
    always_comb begin
        s1_v_d = s1_v_q;
        s1_d   = s1_q;
        if (s1_ld) begin
            s1_v_d = i_valid;
            if (i_valid) begin
                s1_d.op_a = FLP_TC_W'($signed(tc1));
                s1_d.op_b = FLP_TC_W'($signed(tc2));
                s1_d.sa   = i_sn1;
                s1_d.sb   = sb_eff;
                s1_d.acc  = mode_acc;
                s1_d.clr  = mode_clr;
            end
        end
    end

    // ---- S2: add, saturate, back to sign-magnitude ----
    always_comb begin
        is_acc = 1'b0;
        add_a  = $signed(s1_q.op_a);
`ifdef FLP_IADD_PIPE_ACC_EN
        is_acc = s1_q.acc;
        if (s1_q.acc) begin
            add_a = s1_q.clr ? '0 : FLP_TC_W'(acc_q);
        end
`endif
        sum = add_a + $signed(s1_q.op_b);
        res = sum;
`ifdef FLP_IADD_PIPE_ACC_EN
        if (is_acc) begin
            res = saturate(sum);
        end
`endif
        mag = res[FLP_TC_W-1] ? -res : res;

        o_valid_d = o_valid_q;
        o_sn_d    = o_sn_q;
        o_sg_d    = o_sg_q;
        o_zero_d  = o_zero_q;
        o_ovf_d   = o_ovf_q;
        if (s2_ld) begin
            o_valid_d = s1_v_q;
            if (s1_v_q) begin
                // Non-acc keeps -0 + -0 negative; acc results follow the sum only.
                o_sn_d   = is_acc ? res[FLP_TC_W-1] : (res[FLP_TC_W-1] | (s1_q.sa & s1_q.sb));
                o_sg_d   = mag[WIDTH:0];
                o_zero_d = (mag == '0);
                o_ovf_d  = is_acc & (res != sum);
            end
        end
    end

`ifdef FLP_IADD_PIPE_ACC_EN
    always_comb begin
        acc_d = acc_q;
        if (s2_ld & s1_v_q & s1_q.acc) begin
            acc_d = res[WIDTH+1:0];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1_v_q    <= 1'b0;
            o_valid_q <= 1'b0;
            o_sn_q    <= 1'b0;
            o_sg_q    <= '0;
            o_zero_q  <= 1'b0;
            o_ovf_q   <= 1'b0;
        end else begin
            s1_v_q    <= s1_v_d;
            o_valid_q <= o_valid_d;
            o_sn_q    <= o_sn_d;
            o_sg_q    <= o_sg_d;
            o_zero_q  <= o_zero_d;
            o_ovf_q   <= o_ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        s1_q <= s1_d;
    end

    assign o_valid = o_valid_q;
    assign o_sn    = o_sn_q;
    assign o_sg    = o_sg_q;
    assign o_zero  = o_zero_q;
    assign o_ovf   = o_ovf_q;

endmodule

// File: tb/tb_flp_iadd_pipe.sv
// Randomised and directed bench for flp_iadd_pipe (WIDTH=8) against an arithmetic reference model.
module tb_flp_iadd_pipe;

    localparam int W   = 8;
    localparam int SAT = (1 << (W + 1)) - 1;
`ifdef FLP_IADD_PIPE_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         i_valid = 1'b0;
    logic         o_ready;
    logic         i_sn1 = 1'b0, i_sn2 = 1'b0;
    logic [W-1:0] i_sg1 = '0, i_sg2 = '0;
    logic         i_sub = 1'b0, i_acc = 1'b0, i_clr = 1'b0;
    logic         o_valid;
    logic         i_ready = 1'b1;
    logic         o_sn;
    logic [W:0]   o_sg;
    logic         o_zero;
    logic         o_ovf;

    always #5 clk = ~clk;

    flp_iadd_pipe #(.WIDTH(W)) dut (
        .clk(clk), .nrst(nrst), .i_valid(i_valid), .o_ready(o_ready),
        .i_sn1(i_sn1), .i_sn2(i_sn2), .i_sg1(i_sg1), .i_sg2(i_sg2),
        .i_sub(i_sub), .i_acc(i_acc), .i_clr(i_clr),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_sn(o_sn), .o_sg(o_sg), .o_zero(o_zero), .o_ovf(o_ovf)
    );

    typedef struct {
        bit sn;
        int sg;
        bit zero;
        bit ovf;
        int cyc;
        int lat;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   in_cnt = 0;
    int   model_acc = 0;
    bit   rnd_ready = 1'b0;
    res_t exp_q[$];
    res_t obs_q[$];

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Result of one item from plain integer arithmetic.
    function automatic res_t model(bit sn1, int sg1, bit sn2, int sg2, bit sub, bit acc, bit clr);
        res_t r;
        int   a, b, s;
        bit   am;
        am = ACC_EN && acc;
        b  = (sn2 ^ sub) ? -sg2 : sg2;
        if (am) a = clr ? 0 : model_acc;
        else    a = sn1 ? -sg1 : sg1;
        s     = a + b;
        r.ovf = 1'b0;
        if (am) begin
            if (s > SAT) begin s = SAT; r.ovf = 1'b1; end
            else if (s < -SAT) begin s = -SAT; r.ovf = 1'b1; end
            model_acc = s;
            r.sn = (s < 0);
        end else begin
            r.sn = (s < 0) || (sn1 && (sn2 ^ sub));
        end
        r.sg   = (s < 0) ? -s : s;
        r.zero = (r.sg == 0);
        r.cyc  = cyc;
        r.lat  = 0;
        return r;
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (rnd_ready) begin
            #1;
            i_ready = ($urandom % 4) != 0;
        end
    end

    bit         prev_stall = 1'b0;
    logic       prev_sn, prev_zero, prev_ovf;
    logic [W:0] prev_sg;

    always @(negedge clk) begin
        res_t e;
        res_t o;
        if (!nrst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", o_valid, 1);
                chk("hold_sn", o_sn, prev_sn);
                chk("hold_sg", o_sg, prev_sg);
                chk("hold_zero", o_zero, prev_zero);
                chk("hold_ovf", o_ovf, prev_ovf);
            end
            if (i_valid && o_ready) begin
                in_cnt++;
                exp_q.push_back(model(i_sn1, i_sg1, i_sn2, i_sg2, i_sub, i_acc, i_clr));
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("o_sn", o_sn, e.sn);
                    chk("o_sg", o_sg, e.sg);
                    chk("o_zero", o_zero, e.zero);
                    chk("o_ovf", o_ovf, e.ovf);
                    o.sn = o_sn; o.sg = o_sg; o.zero = o_zero; o.ovf = o_ovf;
                    o.cyc = cyc; o.lat = cyc - e.cyc;
                    obs_q.push_back(o);
                end
            end
            prev_stall = o_valid && !i_ready;
            prev_sn = o_sn; prev_sg = o_sg; prev_zero = o_zero; prev_ovf = o_ovf;
        end
    end

    task automatic send(bit sn1, int sg1, bit sn2, int sg2, bit sub, bit acc, bit clr);
        int n = 0;
        i_valid = 1'b1;
        i_sn1 = sn1; i_sg1 = W'(sg1); i_sn2 = sn2; i_sg2 = W'(sg2);
        i_sub = sub; i_acc = acc; i_clr = clr;
        @(negedge clk);
        while (!o_ready) begin
            n++;
            if (n > 200) begin
                chk("send_timeout", n, 0);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_obs(string nm, int idx, bit sn, int sg, bit zero, bit ovf);
        if (idx >= obs_q.size()) begin
            chk({nm, "_count"}, obs_q.size(), idx + 1);
        end else begin
            chk({nm, "_sn"}, obs_q[idx].sn, sn);
            chk({nm, "_sg"}, obs_q[idx].sg, sg);
            chk({nm, "_zero"}, obs_q[idx].zero, zero);
            chk({nm, "_ovf"}, obs_q[idx].ovf, ovf);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   base;
        bit   r_sn1, r_sn2, r_sub, r_acc, r_clr;
        int   r_sg1, r_sg2;

        #12;
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_sn", o_sn, 0);
        chk("rst_o_sg", o_sg, 0);
        chk("rst_o_zero", o_zero, 0);
        chk("rst_o_ovf", o_ovf, 0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        #1;
        chk("rst_o_ready", o_ready, 1);
        wait_cycles(1);

        // Mixed-sign add and subtract, 2-cycle latency.
        obs_q.delete();
        send(1'b0, 5, 1'b1, 3, 1'b0, 1'b0, 1'b0);
        send(1'b1, 200, 1'b0, 55, 1'b1, 1'b0, 1'b0);
        wait_cycles(4);
        chk_obs("add_5_m3", 0, 1'b0, 2, 1'b0, 1'b0);
        chk_obs("sub_m200_55", 1, 1'b1, 255, 1'b0, 1'b0);
        if (obs_q.size() >= 2) begin
            chk("latency0", obs_q[0].lat, 2);
            chk("latency1", obs_q[1].lat, 2);
        end

        // Signed zeros.
        obs_q.delete();
        send(1'b1, 0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        send(1'b0, 7, 1'b0, 7, 1'b1, 1'b0, 1'b0);
        wait_cycles(4);
        chk_obs("neg0_neg0", 0, 1'b1, 0, 1'b1, 1'b0);
        chk_obs("p7_sub_p7", 1, 1'b0, 0, 1'b1, 1'b0);

        // Back-to-back accumulation.
        obs_q.delete();
        send(1'b0, 0, 1'b0, 100, 1'b0, 1'b1, 1'b1);
        send(1'b0, 0, 1'b0, 100, 1'b0, 1'b1, 1'b0);
        send(1'b0, 0, 1'b0, 100, 1'b0, 1'b1, 1'b0);
        send(1'b0, 0, 1'b1, 50, 1'b0, 1'b1, 1'b0);
        wait_cycles(4);
        chk_obs("acc0", 0, 1'b0, 100, 1'b0, 1'b0);
        chk_obs("acc1", 1, 1'b0, ACC_EN ? 200 : 100, 1'b0, 1'b0);
        chk_obs("acc2", 2, 1'b0, ACC_EN ? 300 : 100, 1'b0, 1'b0);
        chk_obs("acc3", 3, ACC_EN ? 1'b0 : 1'b1, ACC_EN ? 250 : 50, 1'b0, 1'b0);
        if (obs_q.size() >= 4) chk("acc_consecutive", obs_q[3].cyc - obs_q[0].cyc, 3);

        // Saturation, then read the held accumulator by adding +0.
        obs_q.delete();
        send(1'b0, 0, 1'b0, 255, 1'b0, 1'b1, 1'b1);
        send(1'b0, 0, 1'b0, 255, 1'b0, 1'b1, 1'b0);
        send(1'b0, 0, 1'b0, 255, 1'b0, 1'b1, 1'b0);
        send(1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        wait_cycles(4);
        chk_obs("sat0", 0, 1'b0, 255, 1'b0, 1'b0);
        chk_obs("sat1", 1, 1'b0, ACC_EN ? 510 : 255, 1'b0, 1'b0);
        chk_obs("sat2", 2, 1'b0, ACC_EN ? 511 : 255, 1'b0, ACC_EN);
        chk_obs("sat_hold", 3, 1'b0, ACC_EN ? 511 : 0, ACC_EN ? 1'b0 : 1'b1, 1'b0);

        // Back-pressure: two accepts fill the pipe, then it stalls.
        obs_q.delete();
        base = in_cnt;
        i_ready = 1'b0;
        fork
            begin
                send(1'b0, 1, 1'b0, 1, 1'b0, 1'b0, 1'b0);
                send(1'b0, 2, 1'b0, 2, 1'b0, 1'b0, 1'b0);
                send(1'b0, 3, 1'b0, 3, 1'b0, 1'b0, 1'b0);
                send(1'b0, 4, 1'b0, 4, 1'b0, 1'b0, 1'b0);
            end
            begin
                repeat (4) @(negedge clk);
                chk("bp_accepts", in_cnt - base, 2);
                chk("bp_o_ready", o_ready, 0);
                chk("bp_o_valid", o_valid, 1);
                chk("bp_o_sg", o_sg, 2);
                @(posedge clk);
                #1;
                i_ready = 1'b1;
            end
        join
        wait_cycles(4);
        chk("bp_count", obs_q.size(), 4);
        chk_obs("bp0", 0, 1'b0, 2, 1'b0, 1'b0);
        chk_obs("bp1", 1, 1'b0, 4, 1'b0, 1'b0);
        chk_obs("bp2", 2, 1'b0, 6, 1'b0, 1'b0);
        chk_obs("bp3", 3, 1'b0, 8, 1'b0, 1'b0);

        // Reset with two items in flight.
        send(1'b0, 0, 1'b0, 20, 1'b0, 1'b1, 1'b0);
        send(1'b0, 0, 1'b0, 30, 1'b0, 1'b1, 1'b0);
        chk("pre_rst_o_valid", o_valid, 1);
        #2;
        nrst = 1'b0;
        exp_q.delete();
        model_acc = 0;
        #1;
        chk("mid_rst_o_valid", o_valid, 0);
        chk("mid_rst_o_sg", o_sg, 0);
        chk("mid_rst_o_sn", o_sn, 0);
        chk("mid_rst_o_ovf", o_ovf, 0);
        wait_cycles(2);
        nrst = 1'b1;
        wait_cycles(1);
        obs_q.delete();
        send(1'b0, 0, 1'b0, 10, 1'b0, 1'b1, 1'b0);
        wait_cycles(4);
        chk("post_rst_count", obs_q.size(), 1);
        chk_obs("post_rst_acc", 0, 1'b0, 10, 1'b0, 1'b0);

        // Random traffic with random back-pressure.
        rnd_ready = 1'b1;
        for (int k = 0; k < 400; k++) begin
            r_sn1 = $urandom % 2;
            r_sn2 = $urandom % 2;
            r_sub = $urandom % 2;
            r_acc = ($urandom % 3) == 0;
            r_clr = ($urandom % 4) == 0;
            case ($urandom % 8)
                0:       r_sg1 = 0;
                1:       r_sg1 = 255;
                default: r_sg1 = $urandom % 256;
            endcase
            case ($urandom % 8)
                0:       r_sg2 = 0;
                1:       r_sg2 = 255;
                default: r_sg2 = $urandom % 256;
            endcase
            send(r_sn1, r_sg1, r_sn2, r_sg2, r_sub, r_acc, r_clr);
        end
        rnd_ready = 1'b0;
        @(posedge clk);
        #2;
        i_ready = 1'b1;
        wait_cycles(6);
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_o_valid", o_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
